// File: rtl/procesxor_pkg.sv
// rtl/procesxor_pkg.sv - shared defaults and fetch-state encoding for the fetch unit
package procesxor_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int ADDR_W_DEF    = 8;
    localparam int RESET_VEC_DEF = 0;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO carrying instruction data and its fetch address
module fetch_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic [ADDR_W-1:0]       push_addr,
    input  logic                    pop,
    input  logic                    flush,
    output logic                    head_valid,
    output logic [DATA_W-1:0]       head_data,
    output logic [ADDR_W-1:0]       head_addr,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Next pointer/count/storage; flush wins over a coincident push or pop.
    always_comb begin
        data_d   = data_q;
        addr_d   = addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = push_data;
                addr_d[wr_ptr_q] = push_addr;
                wr_ptr_d         = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: head outputs are masked while empty.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        addr_q <= addr_d;
    end

    // Head view straight from the registered storage.
    always_comb begin
        head_valid = (count_q != '0);
        head_data  = head_valid ? data_q[rd_ptr_q] : '0;
        head_addr  = head_valid ? addr_q[rd_ptr_q] : '0;
        count      = count_q;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with PC, issue control, redirect flush and prefetch queue
module fetch_unit
    import procesxor_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] dout,
    input  logic              mem_busy,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;

    logic [CNT_W-1:0]  q_count;
    logic [CNT_W-1:0]  occupancy;
    logic              q_head_valid;
    logic [DATA_W-1:0] q_head_data;
    logic [ADDR_W-1:0] q_head_addr;
    logic              issue;
    logic              push;
    logic              pop;

    // Fetch state sequencing: one BOOT cycle, then RUN until halted, redirect resumes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (halt && !redirect) state_d = ST_HALTED;
            ST_HALTED: if (redirect) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    // Issue decision, PC update and in-flight tracking; queued plus in-flight reads never exceed DEPTH.
    always_comb begin
        occupancy  = q_count + CNT_W'(inflight_q);
        issue      = !rst && (state_q == ST_RUN) && !halt && !redirect && !mem_busy
                     && (occupancy < CNT_W'(DEPTH));
        pc_d       = pc_q;
        if (redirect) begin
            pc_d = redirect_addr;
        end else if (issue) begin
            pc_d = pc_q + ADDR_ONE;
        end
        inflight_d = issue;
        push       = inflight_q && !redirect && !rst;
        pop        = instr_valid && instr_ready;
    end

    // State, PC and in-flight registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    // The returning read is tagged with pc_q - 1: the PC advanced on the issue edge.
    fetch_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (dout),
        .push_addr  (pc_q - ADDR_ONE),
        .pop        (pop),
        .flush      (redirect),
        .head_valid (q_head_valid),
        .head_data  (q_head_data),
        .head_addr  (q_head_addr),
        .count      (q_count)
    );

    // Outputs are forced to their idle values while reset is held.
    always_comb begin
        mem_rd      = issue;
        read_addr   = rst ? RESET_VEC : pc_q;
        instr_valid = q_head_valid && !rst;
        instr       = rst ? '0 : q_head_data;
        instr_pc    = rst ? '0 : q_head_addr;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic       rst_next;
    logic       mem_busy;
    logic       instr_ready;
    logic       redirect;
    logic [7:0] redirect_addr;
    logic       halt;

    logic       mem_rd,    fe_mem_rd;
    logic [7:0] read_addr, fe_read_addr;
    logic [7:0] dout,      fe_dout;
    logic [7:0] instr,     fe_instr;
    logic [7:0] instr_pc,  fe_pc;
    logic       instr_valid, fe_valid;

    int         n_checks;
    int         n_fail;
    int         delivered;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    fetch_unit #(.DATA_W(8), .ADDR_W(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .read_addr(read_addr), .dout(dout),
        .mem_busy(mem_busy), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt)
    );

    fetch_unit #(.DATA_W(8), .ADDR_W(8), .DEPTH(4), .RESET_VEC(8'hFE)) dut_fe (
        .clk(clk), .rst(rst), .mem_rd(fe_mem_rd), .read_addr(fe_read_addr), .dout(fe_dout),
        .mem_busy(mem_busy), .instr(fe_instr), .instr_pc(fe_pc), .instr_valid(fe_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data = address + 0x10 one cycle after the read, filler otherwise.
    always @(posedge clk) begin
        dout    <= mem_rd    ? 8'(read_addr + 8'h10)    : 8'hEE;
        fe_dout <= fe_mem_rd ? 8'(fe_read_addr + 8'h10) : 8'hEE;
    end

    // Scoreboard consumer: every accepted instruction must be the next expected address.
    always @(negedge clk) begin
        #2;
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            n_checks++;
            delivered++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h instr %h, expected no transfer", instr_pc, instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (instr_pc !== mon_exp || instr !== 8'(mon_exp + 8'h10)) begin
                    n_fail++;
                    $display("FAIL sb_order: got pc %h instr %h, expected pc %h instr %h",
                             instr_pc, instr, mon_exp, 8'(mon_exp + 8'h10));
                end
            end
        end
    end

    task automatic cyc(input logic rdy, input logic busy, input logic hlt,
                       input logic rd, input logic [7:0] ra);
        @(negedge clk);
        rst           = rst_next;
        instr_ready   = rdy;
        mem_busy      = busy;
        halt          = hlt;
        redirect      = rd;
        redirect_addr = ra;
        #1;
    endtask

    task automatic fill_exp(input logic [7:0] start, input int n);
        logic [7:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 8'h01;
        end
    endtask

    task automatic do_reset();
        rst_next = 1'b1;
        cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);
        rst_next = 1'b0;
        exp_q.delete();
        delivered = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (mem_rd !== 1'b0)      begin n_fail++; $display("FAIL rst_mem_rd: got %b expected 0", mem_rd); end
        n_checks++; if (read_addr !== 8'h00)  begin n_fail++; $display("FAIL rst_read_addr: got %h expected 00", read_addr); end
        n_checks++; if (fe_read_addr !== 8'hFE) begin n_fail++; $display("FAIL rst_fe_read_addr: got %h expected fe", fe_read_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        n_checks++; if (instr !== 8'h00)      begin n_fail++; $display("FAIL rst_instr: got %h expected 00", instr); end
        n_checks++; if (instr_pc !== 8'h00)   begin n_fail++; $display("FAIL rst_instr_pc: got %h expected 00", instr_pc); end
    endtask

    task automatic test_stream();
        do_reset();
        fill_exp(8'h00, 64);
        cyc(1, 0, 0, 0, 8'h00);
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL boot_no_rd: got %b expected 0", mem_rd); end
        cyc(1, 0, 0, 0, 8'h00);
        n_checks++; if (mem_rd !== 1'b1 || read_addr !== 8'h00) begin n_fail++; $display("FAIL first_rd: got rd %b addr %h expected rd 1 addr 00", mem_rd, read_addr); end
        cyc(1, 0, 0, 0, 8'h00);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL data_cycle_valid: got %b expected 0", instr_valid); end
        n_checks++; if (mem_rd !== 1'b1 || read_addr !== 8'h01) begin n_fail++; $display("FAIL second_rd: got rd %b addr %h expected rd 1 addr 01", mem_rd, read_addr); end
        cyc(1, 0, 0, 0, 8'h00);
        n_checks++; if (instr_valid !== 1'b1 || instr !== 8'h10 || instr_pc !== 8'h00) begin n_fail++; $display("FAIL first_instr: got v %b instr %h pc %h expected v 1 instr 10 pc 00", instr_valid, instr, instr_pc); end
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 0, 0, 8'h00);
            n_checks++; if (instr_valid !== 1'b1 || mem_rd !== 1'b1) begin n_fail++; $display("FAIL throughput: cycle %0d got v %b rd %b expected 1 1", i, instr_valid, mem_rd); end
        end
        #2;
        n_checks++; if (delivered != 13) begin n_fail++; $display("FAIL stream_count: got %0d expected 13", delivered); end
    endtask

    task automatic test_reset_vec();
        logic [7:0] fe_tab [4];
        int k;
        fe_tab = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        k = 0;
        do_reset();
        fill_exp(8'h00, 64);
        for (int i = 0; i < 20 && k < 4; i++) begin
            cyc(1, 0, 0, 0, 8'h00);
            if (fe_valid === 1'b1) begin
                n_checks++;
                if (fe_pc !== fe_tab[k] || fe_instr !== 8'(fe_tab[k] + 8'h10)) begin
                    n_fail++;
                    $display("FAIL wrap_seq: got pc %h instr %h expected pc %h instr %h", fe_pc, fe_instr, fe_tab[k], 8'(fe_tab[k] + 8'h10));
                end
                k++;
            end
        end
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL wrap_timeout: got %0d instrs expected 4", k); end
    endtask

    task automatic test_backpressure();
        int   nreads;
        logic seen;
        nreads = 0;
        seen   = 1'b0;
        do_reset();
        fill_exp(8'h00, 64);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0, 8'h00);
            if (mem_rd === 1'b1) begin
                n_checks++; if (read_addr !== 8'(nreads)) begin n_fail++; $display("FAIL bp_addr: got %h expected %h", read_addr, 8'(nreads)); end
                nreads++;
            end
        end
        n_checks++; if (nreads != 4) begin n_fail++; $display("FAIL bp_reads: got %0d expected 4", nreads); end
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %b expected 0", mem_rd); end
        n_checks++; if (instr_valid !== 1'b1 || instr !== 8'h10) begin n_fail++; $display("FAIL bp_head: got v %b instr %h expected v 1 instr 10", instr_valid, instr); end
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 0, 8'h00);
            if (mem_rd === 1'b1 && !seen) begin
                seen = 1'b1;
                n_checks++; if (read_addr !== 8'h04) begin n_fail++; $display("FAIL bp_resume: got %h expected 04", read_addr); end
            end
        end
        #2;
        n_checks++; if (!seen || delivered < 12) begin n_fail++; $display("FAIL bp_drain: got resumed %b delivered %0d expected 1 and >=12", seen, delivered); end
    endtask

    task automatic test_redirect();
        int d0;
        do_reset();
        fill_exp(8'h00, 64);
        cyc(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h80);
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL redir_no_rd: got %b expected 0", mem_rd); end
        exp_q.delete();
        fill_exp(8'h80, 64);
        cyc(1, 0, 0, 0, 8'h00);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b expected 0", instr_valid); end
        n_checks++; if (mem_rd !== 1'b1 || read_addr !== 8'h80) begin n_fail++; $display("FAIL redir_refetch: got rd %b addr %h expected rd 1 addr 80", mem_rd, read_addr); end
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'h00);
        #2;
        n_checks++; if (delivered < 5) begin n_fail++; $display("FAIL redir_stream: got %0d expected >=5", delivered); end
        d0 = delivered;
        cyc(1, 0, 0, 1, 8'h40);
        #2;
        n_checks++; if (delivered != d0 + 1) begin n_fail++; $display("FAIL redir_xfer: got %0d expected %0d", delivered, d0 + 1); end
        cyc(1, 0, 0, 0, 8'h00);
        exp_q.delete();
        fill_exp(8'h40, 64);
        n_checks++; if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || read_addr !== 8'h40) begin n_fail++; $display("FAIL redir2_refetch: got v %b rd %b addr %h expected v 0 rd 1 addr 40", instr_valid, mem_rd, read_addr); end
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'h00);
        #2;
        n_checks++; if (delivered < d0 + 6) begin n_fail++; $display("FAIL redir2_stream: got %0d expected >=%0d", delivered, d0 + 6); end
    endtask

    task automatic test_busy();
        do_reset();
        fill_exp(8'h00, 64);
        cyc(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 8'h00);
            n_checks++; if (mem_rd !== 1'b0 || read_addr !== 8'h06) begin n_fail++; $display("FAIL busy_hold: got rd %b addr %h expected rd 0 addr 06", mem_rd, read_addr); end
        end
        cyc(1, 0, 0, 0, 8'h00);
        n_checks++; if (mem_rd !== 1'b1 || read_addr !== 8'h06) begin n_fail++; $display("FAIL busy_resume: got rd %b addr %h expected rd 1 addr 06", mem_rd, read_addr); end
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'h00);
        #2;
        n_checks++; if (delivered < 12) begin n_fail++; $display("FAIL busy_stream: got %0d expected >=12", delivered); end
    endtask

    task automatic test_halt_reset();
        int nrd;
        nrd = 0;
        do_reset();
        fill_exp(8'h00, 64);
        cyc(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 8'h00);
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_no_rd: got %b expected 0", mem_rd); end
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0, 8'h00);
            if (mem_rd !== 1'b0) nrd++;
        end
        n_checks++; if (nrd != 0) begin n_fail++; $display("FAIL halted_issue: got %0d reads expected 0", nrd); end
        #2;
        n_checks++; if (delivered != 5) begin n_fail++; $display("FAIL halted_drain: got %0d expected 5", delivered); end
        cyc(1, 0, 0, 1, 8'h20);
        exp_q.delete();
        fill_exp(8'h20, 64);
        cyc(1, 0, 0, 0, 8'h00);
        n_checks++; if (mem_rd !== 1'b1 || read_addr !== 8'h20) begin n_fail++; $display("FAIL halt_resume: got rd %b addr %h expected rd 1 addr 20", mem_rd, read_addr); end
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 8'h00);
        rst_next = 1'b1;
        cyc(1, 0, 0, 0, 8'h00);
        rst_next = 1'b0;
        exp_q.delete();
        fill_exp(8'h00, 64);
        n_checks++; if (instr_valid !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got v %b rd %b expected 0 0", instr_valid, mem_rd); end
        cyc(1, 0, 0, 0, 8'h00);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL no_stale: got %b expected 0", instr_valid); end
        cyc(1, 0, 0, 0, 8'h00);
        n_checks++; if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || read_addr !== 8'h00) begin n_fail++; $display("FAIL midrst_refetch: got v %b rd %b addr %h expected v 0 rd 1 addr 00", instr_valid, mem_rd, read_addr); end
        delivered = 0;
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 8'h00);
        #2;
        n_checks++; if (delivered < 4) begin n_fail++; $display("FAIL midrst_stream: got %0d expected >=4", delivered); end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        delivered     = 0;
        rst           = 1'b1;
        rst_next      = 1'b1;
        mem_busy      = 1'b0;
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 8'h00;
        halt          = 1'b0;
        test_reset();
        test_stream();
        test_reset_vec();
        test_backpressure();
        test_redirect();
        test_busy();
        test_halt_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
